// File: rtl/host_uart_tx.sv
// host_uart_tx: FIFO-buffered UART transmitter fed by the Z80 I/O write strobe.
// Frames are 8N1; define HOST_UART_PARITY_EN to add an even-parity bit (8E1).
module host_uart_tx #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] data,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       tx_busy,
  output logic       overflow,
  output logic       uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0]   BAUD_ONE  = 16'd1;
  localparam logic [15:0]   BAUD_ZERO = 16'd0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef HOST_UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

`ifdef HOST_UART_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          fifo_full_r;
  logic          fifo_empty_r;
  logic          tx_busy_r;
  logic          overflow_r;

  state_t        state_r;
  logic [15:0]   baud_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          uart_tx_r;
`ifdef HOST_UART_PARITY_EN
  logic          parity_r;
`endif

  logic          push_s;
  logic          pop_s;
  logic          baud_tc_s;
  logic          stop_end_s;
  logic          idle_next_s;
  logic [7:0]    head_s;

  assign head_s = mem_r[rd_ptr_r];

  // Push/pop qualification and next FIFO occupancy.
  always_comb begin
    baud_tc_s  = (baud_cnt_r == BAUD_LAST);
    stop_end_s = (state_r == S_STOP) && baud_tc_s;
    // A write against a registered-full FIFO is dropped even if a pop happens this cycle.
    push_s     = wr && !fifo_full_r;
    if ((state_r == S_IDLE) || stop_end_s) begin
      pop_s = !fifo_empty_r;
    end else begin
      pop_s = 1'b0;
    end
    idle_next_s = !pop_s && ((state_r == S_IDLE) || stop_end_s);
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // FIFO pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      fifo_full_r  <= 1'b0;
      fifo_empty_r <= 1'b1;
      tx_busy_r    <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (wr && fifo_full_r) begin
        overflow_r <= 1'b1;
      end
      count_r      <= count_next_s;
      fifo_full_r  <= (count_next_s == CNT_FULL);
      fifo_empty_r <= (count_next_s == CNT_ZERO);
      tx_busy_r    <= !idle_next_s || (count_next_s != CNT_ZERO);
    end
  end

  // Transmit FSM; uart_tx is driven straight from uart_tx_r.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      uart_tx_r  <= 1'b1;
`ifdef HOST_UART_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else if (pop_s) begin
      // Pop from IDLE or from the last stop clock: start bit begins next cycle.
      state_r    <= S_START;
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= head_s;
      uart_tx_r  <= 1'b0;
`ifdef HOST_UART_PARITY_EN
      parity_r   <= even_parity(head_s);
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          uart_tx_r  <= 1'b1;
          baud_cnt_r <= BAUD_ZERO;
        end
        S_START: begin
          if (baud_tc_s) begin
            state_r    <= S_DATA;
            baud_cnt_r <= BAUD_ZERO;
            uart_tx_r  <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_tc_s) begin
            baud_cnt_r <= BAUD_ZERO;
            if (bit_cnt_r == 3'd7) begin
`ifdef HOST_UART_PARITY_EN
              state_r   <= S_PARITY;
              uart_tx_r <= parity_r;
`else
              state_r   <= S_STOP;
              uart_tx_r <= 1'b1;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              uart_tx_r <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
`ifdef HOST_UART_PARITY_EN
        S_PARITY: begin
          if (baud_tc_s) begin
            state_r    <= S_STOP;
            baud_cnt_r <= BAUD_ZERO;
            uart_tx_r  <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
`endif
        S_STOP: begin
          if (baud_tc_s) begin
            state_r    <= S_IDLE;
            baud_cnt_r <= BAUD_ZERO;
            uart_tx_r  <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          baud_cnt_r <= BAUD_ZERO;
          uart_tx_r  <= 1'b1;
        end
      endcase
    end
  end

  assign fifo_full  = fifo_full_r;
  assign fifo_empty = fifo_empty_r;
  assign tx_busy    = tx_busy_r;
  assign overflow   = overflow_r;
  assign uart_tx    = uart_tx_r;

endmodule

// File: doc/host_uart_tx.md
# host_uart_tx

Buffered UART transmitter for the host board. Accepts bytes from the Z80 I/O write path, queues them in a small FIFO, and serialises them onto the board's `uart_tx` pin as 8N1 frames, or 8E1 when parity is compiled in. It sits between the Z80 I/O port decoder and the `uart_tx` output of the `host` top level. It runs on the 50 MHz board clock.

## Interface
- `BAUD_DIV`, 434: clocks per bit. 434 gives 115200 baud at 50 MHz. Legal range is 2..65535.
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of two, 2..256.

Ports:
- `clk` in 1: board clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr` in 1: one-cycle write strobe from the I/O decoder.
- `data` in 8: byte to send, sampled when `wr` is high.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `fifo_empty` out 1: FIFO holds 0 entries.
- `tx_busy` out 1: a frame is in progress, or the FIFO is non-empty.
- `overflow` out 1: sticky; set when a write is dropped.
- `uart_tx` out 1: serial line, idles high.

## Operation
- Reset values: `uart_tx`=1, `fifo_empty`=1, `fifo_full`=0, `tx_busy`=0, `overflow`=0. FIFO pointers, count, baud counter and bit counter are all cleared.
- FIFO:
  - Write pointer, read pointer and a count register of width log2(FIFO_DEPTH)+1.
  - `fifo_full` and `fifo_empty` decode from the registered count.
- Write handling:
  - `wr` with `fifo_full`=0 stores `data` at the write pointer and increments the pointer. The pointer wraps modulo `FIFO_DEPTH`.
  - `wr` with `fifo_full`=1 drops the byte, leaves the FIFO unchanged and sets `overflow`. Only `reset` clears `overflow`.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. This holds at count=`FIFO_DEPTH`, where the pop happens and the write is still dropped because full is registered.
- Transmit FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: `uart_tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter and go to START.
  - START: `uart_tx`=0 for `BAUD_DIV` clocks, then go to DATA.
  - DATA: send bit 0 first. Shift right every `BAUD_DIV` clocks. After 8 bits go to PARITY if compiled in, otherwise to STOP.
  - PARITY: `uart_tx` = XOR of the 8 data bits (even parity) for `BAUD_DIV` clocks.
  - STOP: `uart_tx`=1 for `BAUD_DIV` clocks. On the final clock, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Baud counter counts 0..`BAUD_DIV`-1. The bit boundary is at terminal count.
- `tx_busy` = (state != IDLE) OR (`fifo_empty`=0).
- Reset asserted mid-frame aborts the frame immediately: `uart_tx` returns to 1 and queued bytes are discarded.

## Timing
- Latency with the FIFO empty and the FSM in IDLE: `wr` sampled at edge k; `uart_tx` falls after edge k+1.
- Each bit lasts exactly `BAUD_DIV` clocks.
- Frame length: 10×`BAUD_DIV` clocks, or 11×`BAUD_DIV` with parity.
- Back-to-back frames: the next start bit begins on the clock immediately after the last stop-bit clock.
- `fifo_empty`, `fifo_full` and `overflow` update on the edge that samples the causing event.
- `uart_tx` is driven directly from a flop, so it is glitch-free.

## Configuration
- `HOST_UART_PARITY_EN` defined: the PARITY state is included and frames are 8E1, 11 bits.
- `HOST_UART_PARITY_EN` undefined: PARITY state and XOR logic are absent and frames are 8N1, 10 bits.
- No other behaviour changes.

## Test plan
All scenarios use `BAUD_DIV`=4 and `FIFO_DEPTH`=4.
- Reset, then one `wr` of 0x55 → `uart_tx` falls 2 edges after `wr`. Line sequence is 0,1,0,1,0,1,0,1,0,1, each level held 4 clocks, 40 clocks total. `tx_busy` drops on the clock after the stop bit ends.
- Three consecutive `wr` of 0x01, 0x80, 0xFF → three contiguous frames with no idle cycle between them. Data bits decode LSB-first to 0x01, 0x80, 0xFF. `fifo_empty`=1 after the third pop.
- Six writes in six consecutive clocks with the FSM idle → the first byte is popped, four are queued, `fifo_full`=1. The sixth write is dropped and `overflow`=1 stays set. Exactly five frames are emitted.
- Write on the cycle the FSM pops from a full FIFO → the write is dropped, `overflow`=1, pointers still wrap correctly, and later frames carry the right bytes.
- `reset` pulled low 13 clocks into a frame of 0xA5 → `uart_tx`=1 asynchronously, FIFO empty, `tx_busy`=0. After release, a write of 0x3C transmits correctly.
- With `HOST_UART_PARITY_EN` defined: 0x07 → parity bit 1 and a 44-clock frame. 0x03 → parity bit 0.
